// File: rtl/fwd_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_ctrl -- decode-stage forwarding / load-use controller
//
// Remembers the destination of the three most recently issued instructions
// and, for the instruction currently decoding, picks where each operand
// should come from: the register bank or one of the in-flight results
// (ans_ex, ans_dm, ans_wb). It also raises a one-cycle stall when an
// operand depends on a load issued in the immediately preceding slot, and
// presents the DM-stage write address/qualifier to the register bank.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   instr_valid  decode slot holds a real instruction
//   RA, RB       source registers of the decoding instruction
//   RW           destination register of the decoding instruction
//   wr_en        decoding instruction writes RW
//   is_load      decoding instruction is a memory load
//   imm_in       operand B is the immediate, RB unused
//   mux_sel_A    A select (00 bank, 01 ans_ex, 10 ans_dm, 11 ans_wb), registered
//   mux_sel_B    B select, same encoding, registered
//   imm_sel      B = immediate, registered
//   RW_dm        bank write address paired with ans_dm
//   wr_dm        bank write qualifier for RW_dm
//   stall        hold decode and fetch this cycle (combinational)
//
// Build option
//   FWD_R0_BLOCK_EN  when defined, register 0 is hard-wired zero: a source of
//                    0 never forwards or stalls, and writes to R0 are never
//                    qualified on wr_dm.
// ---------------------------------------------------------------------------
module fwd_ctrl #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW,
  input  logic              wr_en,
  input  logic              is_load,
  input  logic              imm_in,
  output logic [1:0]        mux_sel_A,
  output logic [1:0]        mux_sel_B,
  output logic              imm_sel,
  output logic [ADDR_W-1:0] RW_dm,
  output logic              wr_dm,
  output logic              stall
);

`ifdef FWD_R0_BLOCK_EN
  localparam logic R0_BLOCK = 1'b1;
`else
  localparam logic R0_BLOCK = 1'b0;
`endif

  // History slots: s1 is the previous instruction, s3 the oldest tracked one.
  logic [ADDR_W-1:0] s1_rw, s2_rw, s3_rw;
  logic              s1_we, s2_we, s3_we;
  logic              s1_ld;
  logic              s2_ld, s3_ld;

  logic              accept;
  logic [1:0]        code_a, code_b;
  logic              a_usable, b_usable;

  // A source of R0 is treated as "always the bank" when R0 is blocked.
  assign a_usable = !(R0_BLOCK && (RA == '0));
  assign b_usable = !(R0_BLOCK && (RB == '0));

  // Youngest matching producer wins, so the checks run s1 -> s2 -> s3.
  function automatic logic [1:0] pick_source(
    input logic              usable,
    input logic [ADDR_W-1:0] src,
    input logic              we1, we2, we3,
    input logic [ADDR_W-1:0] rw1, rw2, rw3
  );
    logic [1:0] code;
    code = 2'b00;
    if (usable) begin
      if (we1 && (rw1 == src))      code = 2'b01;
      else if (we2 && (rw2 == src)) code = 2'b10;
      else if (we3 && (rw3 == src)) code = 2'b11;
    end
    return code;
  endfunction

  always_comb begin
    code_a = pick_source(a_usable, RA, s1_we, s2_we, s3_we, s1_rw, s2_rw, s3_rw);
    code_b = pick_source(b_usable, RB, s1_we, s2_we, s3_we, s1_rw, s2_rw, s3_rw);
  end

  // A load result is not available in ans_ex, so a consumer directly behind
  // a load waits one cycle; by then the load sits in s2 and forwards via 10.
  always_comb begin
    stall = 1'b0;
    if (instr_valid && s1_we && s1_ld) begin
      if (a_usable && (RA == s1_rw))
        stall = 1'b1;
      if (!imm_in && b_usable && (RB == s1_rw))
        stall = 1'b1;
    end
  end

  assign accept = instr_valid && !stall;

  // Slot shift register; a rejected or empty decode slot enters as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rw <= '0;
      s1_we <= 1'b0;
      s1_ld <= 1'b0;
      s2_rw <= '0;
      s2_we <= 1'b0;
      s2_ld <= 1'b0;
      s3_rw <= '0;
      s3_we <= 1'b0;
      s3_ld <= 1'b0;
    end else begin
      s3_rw <= s2_rw;
      s3_we <= s2_we;
      s3_ld <= s2_ld;
      s2_rw <= s1_rw;
      s2_we <= s1_we;
      s2_ld <= s1_ld;
      s1_rw <= RW;
      s1_we <= wr_en && accept;
      s1_ld <= is_load && accept;
    end
  end

  // Operand selects line up with the bank's registered AR/BR read, one cycle
  // after decode. A rejected slot drives the neutral 00/00/0.
  always_ff @(posedge clk) begin
    if (rst) begin
      mux_sel_A <= 2'b00;
      mux_sel_B <= 2'b00;
      imm_sel   <= 1'b0;
    end else if (accept) begin
      mux_sel_A <= code_a;
      mux_sel_B <= imm_in ? 2'b00 : code_b;
      imm_sel   <= imm_in;
    end else begin
      mux_sel_A <= 2'b00;
      mux_sel_B <= 2'b00;
      imm_sel   <= 1'b0;
    end
  end

  // RW_dm/wr_dm track s3 exactly: they load the value s3 is about to take.
  always_ff @(posedge clk) begin
    if (rst) begin
      RW_dm <= '0;
      wr_dm <= 1'b0;
    end else begin
      RW_dm <= s2_rw;
      wr_dm <= s2_we && !(R0_BLOCK && (s2_rw == '0));
    end
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_ctrl -- directed self-checking bench for fwd_ctrl
//
// Inputs change 1 time unit after each rising edge; registered outputs are
// sampled at that same point, i.e. they reflect the instruction presented
// before the edge. stall is combinational and is sampled 1 unit after the
// inputs change, still well away from the next edge.
// ---------------------------------------------------------------------------
module tb_fwd_ctrl;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic [4:0] RA, RB, RW;
  logic       wr_en, is_load, imm_in;
  logic [1:0] mux_sel_A, mux_sel_B;
  logic       imm_sel;
  logic [4:0] RW_dm;
  logic       wr_dm;
  logic       stall;

  int vecCount  = 0;
  int missCount = 0;

`ifdef FWD_R0_BLOCK_EN
  localparam logic [1:0] R0_FWD_CODE = 2'b00;
  localparam logic       R0_WR_DM    = 1'b0;
`else
  localparam logic [1:0] R0_FWD_CODE = 2'b01;
  localparam logic       R0_WR_DM    = 1'b1;
`endif

  fwd_ctrl #(.ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .RA         (RA),
    .RB         (RB),
    .RW         (RW),
    .wr_en      (wr_en),
    .is_load    (is_load),
    .imm_in     (imm_in),
    .mux_sel_A  (mux_sel_A),
    .mux_sel_B  (mux_sel_B),
    .imm_sel    (imm_sel),
    .RW_dm      (RW_dm),
    .wr_dm      (wr_dm),
    .stall      (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                               input logic [4:0] rw, input logic we, input logic ld,
                               input logic imm);
    instr_valid = v;
    RA          = ra;
    RB          = rb;
    RW          = rw;
    wr_en       = we;
    is_load     = ld;
    imm_in      = imm;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction and advance past the edge that accepts it.
  task automatic issue(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                       input logic we, input logic ld, input logic imm);
    applyStimulus(1'b1, ra, rb, rw, we, ld, imm);
    tick();
  endtask

  // Unrelated instruction: reads registers never written, writes nothing.
  task automatic filler;
    issue(5'd30, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush;
    filler();
    filler();
    filler();
  endtask

  task automatic checkSel(input string tag, input logic [1:0] a, input logic [1:0] b,
                          input logic imm);
    checkOutput({tag, "_selA"}, {30'd0, mux_sel_A}, {30'd0, a});
    checkOutput({tag, "_selB"}, {30'd0, mux_sel_B}, {30'd0, b});
    checkOutput({tag, "_imm"},  {31'd0, imm_sel},   {31'd0, imm});
  endtask

  task automatic checkStall(input string tag, input logic exp);
    #1;
    checkOutput(tag, {31'd0, stall}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset state
    checkSel("reset", 2'b00, 2'b00, 1'b0);
    checkOutput("reset_RWdm", {27'd0, RW_dm}, 32'd0);
    checkOutput("reset_wrdm", {31'd0, wr_dm}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // Back-to-back ALU: R3 written, next instruction reads R3 on A
    issue(5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0);
    checkSel("alu_first", 2'b00, 2'b00, 1'b0);
    applyStimulus(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
    checkStall("alu_stall", 1'b0);
    tick();
    checkSel("alu_fwd", 2'b01, 2'b00, 1'b0);

    // Distance 2, 3 and 4 producers of R5
    flush();
    issue(5'd30, 5'd31, 5'd5, 1'b1, 1'b0, 1'b0);
    filler();
    issue(5'd5, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
    checkSel("dist2", 2'b10, 2'b00, 1'b0);
    issue(5'd30, 5'd31, 5'd5, 1'b1, 1'b0, 1'b0);
    filler();
    filler();
    issue(5'd5, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
    checkSel("dist3", 2'b11, 2'b00, 1'b0);
    issue(5'd30, 5'd31, 5'd5, 1'b1, 1'b0, 1'b0);
    flush();
    issue(5'd5, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
    checkSel("dist4", 2'b00, 2'b00, 1'b0);

    // RA == RB both forwarded from the previous write
    issue(5'd30, 5'd31, 5'd9, 1'b1, 1'b0, 1'b0);
    issue(5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
    checkSel("ra_eq_rb", 2'b01, 2'b01, 1'b0);

    // Empty decode slot: bubble on outputs, producer slides to s2
    issue(5'd30, 5'd31, 5'd11, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd11, 5'd11, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkSel("invalid_bubble", 2'b00, 2'b00, 1'b0);
    issue(5'd11, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
    checkSel("after_bubble", 2'b10, 2'b00, 1'b0);

    // Load-use on B: one stall cycle, bubble, then forward from ans_dm
    flush();
    issue(5'd30, 5'd31, 5'd7, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd12, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    checkStall("lu_stall_on", 1'b1);
    tick();
    checkSel("lu_bubble", 2'b00, 2'b00, 1'b0);
    checkOutput("lu_stall_off", {31'd0, stall}, 32'd0);
    tick();
    checkSel("lu_redecode", 2'b00, 2'b10, 1'b0);

    // Load followed by an immediate-B user of the same register
    flush();
    issue(5'd30, 5'd31, 5'd7, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd12, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1);
    checkStall("lu_imm_nostall", 1'b0);
    tick();
    checkSel("lu_imm", 2'b00, 2'b00, 1'b1);

    // Priority: R2 written three times, RW_dm/wr_dm tracking the oldest
    flush();
    issue(5'd30, 5'd31, 5'd2, 1'b1, 1'b0, 1'b0);
    issue(5'd30, 5'd31, 5'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("prio_wrdm_early", {31'd0, wr_dm}, 32'd0);
    issue(5'd30, 5'd31, 5'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("prio_RWdm", {27'd0, RW_dm}, 32'd2);
    checkOutput("prio_wrdm", {31'd0, wr_dm}, 32'd1);
    issue(5'd2, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
    checkSel("prio_youngest", 2'b01, 2'b00, 1'b0);

    // Reset while a load-use stall is active
    flush();
    issue(5'd30, 5'd31, 5'd7, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd12, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    checkStall("rst_stall_on", 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkSel("rst_mid", 2'b00, 2'b00, 1'b0);
    checkOutput("rst_mid_wrdm", {31'd0, wr_dm}, 32'd0);
    checkOutput("rst_mid_stall", {31'd0, stall}, 32'd0);
    issue(5'd7, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
    checkSel("rst_after", 2'b00, 2'b00, 1'b0);

    // Register 0 behaviour depends on the build option
    flush();
    issue(5'd30, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0);
    issue(5'd0, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0);
    checkSel("r0_fwd", R0_FWD_CODE, 2'b00, 1'b0);
    filler();
    checkOutput("r0_RWdm", {27'd0, RW_dm}, 32'd0);
    checkOutput("r0_wrdm", {31'd0, wr_dm}, {31'd0, R0_WR_DM});

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
